// File: rtl/waveform_phase_acc.sv
// Phase accumulator for the waveform generator: FCW step, output offset,
// and FCW hand-over either immediately or at the next phase wrap.

module adder_flex_no_carry #(
    parameter int W = 15
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + i_b + W'(i_cin);

endmodule

module waveform_phase_acc #(
    parameter int PHASE_W = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_sync,
    input  logic               i_upd_mode,
    input  logic               i_fcw_valid,
    input  logic [PHASE_W-1:0] i_fcw,
    output logic               o_fcw_ready,
    input  logic [PHASE_W-1:0] i_phase_ofs,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_valid,
    output logic               o_wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_fcw_act;
    logic [PHASE_W-1:0] r_fcw_pend;
    logic               r_v1;
    logic               r_w1;

    logic [PHASE_W-1:0] w_nxt;
    logic [PHASE_W-1:0] w_ofs_sum;
    logic               w_wrap;
    logic               w_accept;
    logic [PHASE_W-1:0] w_acc_n;
    logic [PHASE_W-1:0] w_act_n;
    logic [PHASE_W-1:0] w_pend_n;

    adder_flex_no_carry #(.W(PHASE_W)) u_step (
        .i_a   (r_acc),
        .i_b   (r_fcw_act),
        .i_cin (1'b0),
        .o_sum (w_nxt)
    );

    adder_flex_no_carry #(.W(PHASE_W)) u_ofs (
        .i_a   (r_acc),
        .i_b   (i_phase_ofs),
        .i_cin (1'b0),
        .o_sum (w_ofs_sum)
    );

    assign w_wrap      = (w_nxt < r_acc);
    assign o_fcw_ready = (r_state != PEND) & ~i_rst;
    assign w_accept    = i_fcw_valid & o_fcw_ready;

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_act_n   = r_fcw_act;
        w_pend_n  = r_fcw_pend;
        if (i_sync) begin
            // Sync discards continuity, so any word goes live now.
            w_acc_n   = '0;
            w_state_n = i_en ? RUN : IDLE;
            if (r_state == PEND)
                w_act_n = r_fcw_pend;
            if (w_accept)
                w_act_n = i_fcw;
        end else begin
            if (i_en)
                w_acc_n = w_nxt;
            unique case (r_state)
                IDLE: begin
                    if (w_accept)
                        w_act_n = i_fcw;
                    if (i_en)
                        w_state_n = RUN;
                end
                RUN: begin
                    if (!i_en) begin
                        w_state_n = IDLE;
                        if (w_accept)
                            w_act_n = i_fcw;
                    end else if (w_accept) begin
                        if (i_upd_mode) begin
                            w_pend_n  = i_fcw;
                            w_state_n = PEND;
                        end else begin
                            w_act_n = i_fcw;
                        end
                    end
                end
                PEND: begin
                    if (!i_en) begin
                        w_act_n   = r_fcw_pend;
                        w_state_n = IDLE;
                    end else if (w_wrap) begin
                        w_act_n   = r_fcw_pend;
                        w_state_n = RUN;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_fcw_act  <= '0;
            r_fcw_pend <= '0;
            r_v1       <= 1'b0;
            r_w1       <= 1'b0;
            o_phase    <= '0;
            o_valid    <= 1'b0;
            o_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_acc      <= w_acc_n;
            r_fcw_act  <= w_act_n;
            r_fcw_pend <= w_pend_n;
            r_v1       <= i_en & ~i_sync;
            r_w1       <= i_en & w_wrap & ~i_sync;
            o_phase    <= w_ofs_sum;
            o_valid    <= r_v1;
            o_wrap     <= r_w1;
        end
    end

endmodule

// File: tb/tb_waveform_phase_acc.sv
// Directed vector bench for waveform_phase_acc with PHASE_W = 15.
// Each row drives one cycle and checks outputs just after the edge.

module tb_waveform_phase_acc;

    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sync;
    logic         mode;
    logic         fv;
    logic [W-1:0] fcw;
    logic         ready;
    logic [W-1:0] ofs;
    logic [W-1:0] phase;
    logic         valid;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    waveform_phase_acc #(.PHASE_W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sync      (sync),
        .i_upd_mode  (mode),
        .i_fcw_valid (fv),
        .i_fcw       (fcw),
        .o_fcw_ready (ready),
        .i_phase_ofs (ofs),
        .o_phase     (phase),
        .o_valid     (valid),
        .o_wrap      (wrap)
    );

    typedef struct {
        bit           rst;
        bit           en;
        bit           sync;
        bit           fv;
        bit           mode;
        logic [W-1:0] fcw;
        logic [W-1:0] ofs;
        logic [W-1:0] ph;
        bit           v;
        bit           w;
        bit           r;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input bit r_, input bit e_, input bit s_,
                       input bit f_, input bit m_,
                       input logic [W-1:0] fc, input logic [W-1:0] of,
                       input logic [W-1:0] ph, input bit v_,
                       input bit w_, input bit rd);
        vec_t t;
        t.rst = r_; t.en = e_; t.sync = s_; t.fv = f_; t.mode = m_;
        t.fcw = fc; t.ofs = of; t.ph = ph; t.v = v_; t.w = w_; t.r = rd;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; mode = 1'b0;
        fv = 1'b0; fcw = '0; ofs = '0;

        // Basic run, FCW 0x1000 immediate
        row(0,0,0,1,0,15'h1000,0, 15'h0000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h1000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h2000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h3000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h4000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h5000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h6000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h7000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,1,1);
        row(0,1,0,0,0,0,0,        15'h1000,1,0,1);
        // Wrap-deferred update to 0x0800
        row(0,1,0,1,1,15'h0800,0, 15'h2000,1,0,0);
        row(0,1,0,0,0,0,0,        15'h3000,1,0,0);
        row(0,1,0,0,0,0,0,        15'h4000,1,0,0);
        row(0,1,0,0,0,0,0,        15'h5000,1,0,0);
        row(0,1,0,0,0,0,0,        15'h6000,1,0,0);
        row(0,1,0,0,0,0,0,        15'h7000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,1,1);
        row(0,1,0,0,0,0,0,        15'h0800,1,0,1);
        row(0,1,0,0,0,0,0,        15'h1000,1,0,1);
        // Immediate updates
        row(0,1,0,1,0,15'h1000,0, 15'h1800,1,0,1);
        row(0,1,0,0,0,0,0,        15'h2000,1,0,1);
        row(0,1,0,1,0,15'h0800,0, 15'h3000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h4000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h4800,1,0,1);
        // Sync with FCW 0x2000 (mode 1 ignored), offset 0x4000
        row(0,1,1,1,1,15'h2000,15'h4000, 15'h1000,1,0,1);
        row(0,1,0,0,0,0,15'h4000,        15'h4000,0,0,1);
        row(0,1,0,0,0,0,15'h4000,        15'h6000,1,0,1);
        row(0,1,0,0,0,0,15'h4000,        15'h0000,1,0,1);
        row(0,1,0,0,0,0,15'h4000,        15'h2000,1,0,1);
        row(0,1,0,0,0,0,15'h4000,        15'h4000,1,1,1);
        row(0,1,0,0,0,0,0,               15'h2000,1,0,1);
        // Enable dropped for 3 cycles
        row(0,0,0,0,0,0,0,        15'h4000,1,0,1);
        row(0,0,0,0,0,0,0,        15'h4000,0,0,1);
        row(0,0,0,0,0,0,0,        15'h4000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h4000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h6000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,1,1);
        // PEND then sync applies pending word
        row(0,1,0,1,1,15'h1000,0, 15'h2000,1,0,0);
        row(0,1,1,0,0,0,0,        15'h4000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h1000,1,0,1);
        // Reset in RUN, restart with FCW 0
        row(1,1,0,0,0,0,0,        15'h0000,0,0,0);
        row(0,1,0,0,0,0,0,        15'h0000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,0,1);
        row(0,1,0,1,0,15'h0800,0, 15'h0000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,0,1);
        row(0,1,0,0,0,0,0,        15'h0800,1,0,1);
        // FCW 0 in PEND: left only by dropping enable
        row(0,1,0,1,0,15'h0000,0, 15'h1000,1,0,1);
        row(0,1,0,1,1,15'h0400,0, 15'h1800,1,0,0);
        row(0,1,0,0,0,0,0,        15'h1800,1,0,0);
        row(0,1,0,0,0,0,0,        15'h1800,1,0,0);
        row(0,0,0,0,0,0,0,        15'h1800,1,0,1);
        row(0,1,0,0,0,0,0,        15'h1800,0,0,1);
        row(0,1,0,0,0,0,0,        15'h1c00,1,0,1);
        // Reset while PEND discards pending word
        row(0,1,0,1,1,15'h2000,0, 15'h2000,1,0,0);
        row(1,1,0,0,0,0,0,        15'h0000,0,0,0);
        row(0,1,0,0,0,0,0,        15'h0000,0,0,1);
        row(0,1,0,0,0,0,0,        15'h0000,1,0,1);

        // Reset state and combinational ready release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", -1, phase, '0);
        chk("rst_valid", -1, W'(valid), '0);
        chk("rst_wrap", -1, W'(wrap), '0);
        chk("rst_ready", -1, W'(ready), '0);
        rst = 1'b0;
        #1;
        chk("ready_release", -1, W'(ready), W'(1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            en   = vecs[i].en;
            sync = vecs[i].sync;
            fv   = vecs[i].fv;
            mode = vecs[i].mode;
            fcw  = vecs[i].fcw;
            ofs  = vecs[i].ofs;
            @(posedge clk);
            #1;
            chk("phase", i, phase, vecs[i].ph);
            chk("valid", i, W'(valid), W'(vecs[i].v));
            chk("wrap", i, W'(wrap), W'(vecs[i].w));
            chk("ready", i, W'(ready), W'(vecs[i].r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/waveform_phase_acc.md
# waveform_phase_acc

Phase accumulator stage of the waveform generator: each enabled cycle it adds a frequency control word (FCW) to a PHASE_W-bit phase register, modulo 2^PHASE_W. It then adds a static phase offset and presents the registered phase to the phase-to-amplitude stage downstream. Both sums use `adder_flex_no_carry` instances with cin tied to 0. New FCWs arrive over a valid/ready handshake and are applied either immediately or phase-continuously at the next wrap.

## Interface
- PHASE_W, 15: accumulator, FCW, offset and output phase width; legal range ≥ 1.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  advance the accumulator this cycle; when low the accumulator holds.
- i_sync  in  1  phase clear; accumulator becomes 0 on this edge.
- i_upd_mode  in  1  FCW apply policy: 0 = immediate, 1 = at next wrap.
- i_fcw_valid  in  1  a new FCW is offered.
- i_fcw  in  PHASE_W  new FCW, unsigned.
- o_fcw_ready  out  1  block can accept an FCW.
- i_phase_ofs  in  PHASE_W  phase offset added at the output, unsigned modulo 2^PHASE_W.
- o_phase  out  PHASE_W  registered phase, equal to acc + i_phase_ofs.
- o_valid  out  1  o_phase is a live sample.
- o_wrap  out  1  acc wrapped past 2^PHASE_W on the step that produced this o_phase.

## Operation
- Registers:
  - acc (PHASE_W)
  - fcw_act (PHASE_W)
  - fcw_pend (PHASE_W)
  - state in {IDLE, RUN, PEND}
  - v1, w1 (stage-1 valid and wrap)
  - o_phase, o_valid, o_wrap
- Sum: nxt = acc + fcw_act, truncated to PHASE_W.
- Wrap flag: wrap = (nxt < acc), unsigned.
- An FCW is accepted when i_fcw_valid & o_fcw_ready at a rising edge.
- o_fcw_ready = (state != PEND) & ~i_rst. It is combinational.
- Priority on each edge: i_rst > i_sync > normal operation.
- i_rst:
  - acc, fcw_act and fcw_pend go to 0.
  - state goes to IDLE.
  - v1, w1, o_phase, o_valid and o_wrap go to 0.
  - A reset in mid-operation discards any pending FCW.
- i_sync:
  - acc <= 0 and w1 <= 0.
  - If state is PEND: fcw_act <= fcw_pend, and state goes to RUN if i_en, else IDLE.
  - An FCW accepted on the same edge is applied immediately, whatever i_upd_mode is.
- State transitions:
  - IDLE: i_en=1 → RUN. Otherwise acc holds.
  - RUN: acc <= nxt when i_en. i_en=0 → IDLE.
  - RUN, FCW accepted with i_upd_mode=0: fcw_act <= i_fcw; stay in RUN.
  - RUN, FCW accepted with i_upd_mode=1: fcw_pend <= i_fcw; go to PEND.
  - IDLE, FCW accepted: fcw_act <= i_fcw immediately, for either mode.
  - PEND: acc <= nxt each cycle while i_en.
  - PEND, edge where wrap=1: fcw_act <= fcw_pend; go to RUN.
  - PEND, i_en=0: fcw_act <= fcw_pend; go to IDLE. No phase continuity is required while stopped.
- Stage 1:
  - v1 <= i_en & ~i_sync.
  - w1 <= i_en & wrap & ~i_sync.
- Stage 2:
  - o_phase <= acc + i_phase_ofs, using the updated acc (stage-1 value) and i_phase_ofs sampled at that edge.
  - o_valid <= v1.
  - o_wrap <= w1.
- FCW = 0 is legal: acc freezes and wrap is never raised. In PEND it is left only by i_en=0, i_sync or i_rst.

## Timing
- Reset values:
  - o_phase = 0, o_valid = 0, o_wrap = 0.
  - o_fcw_ready = 0 while i_rst is high, 1 on the first cycle after.
- Latency: i_en sampled high at edge k → acc advanced at edge k → o_phase reflects it after edge k+1, with o_valid = 1. Two cycles from input to o_valid.
- Throughput: one phase step per cycle.
- Immediate update: an FCW accepted at edge k is used for the step at edge k+1. The step at edge k still uses the old FCW.
- Wrap update: the wrapping step at edge k uses the old FCW; the new FCW is used from edge k+1. o_fcw_ready returns high after edge k.
- o_wrap pulses for one cycle, coincident with the first post-wrap o_phase.
- i_phase_ofs changes take effect at the next o_phase update, one cycle later, with no other side effects.

## Test plan
- Reset, then i_fcw=0x1000 with i_upd_mode=0 and i_en=1 held → o_phase sequence 0x1000, 0x2000, … 0x7000, 0x0000. o_wrap=1 only on the 0x0000 sample. o_valid rises two cycles after i_en.
- Running FCW=0x1000 at acc=0x2000, issue i_fcw=0x0800 with i_upd_mode=1 → o_fcw_ready low until the wrap. Steps stay 0x1000 through the wrap to 0x0000, then become 0x0800. o_fcw_ready goes high the cycle after the wrap.
- Same stimulus with i_upd_mode=0 → the next step after acceptance is still 0x1000; every step after that is 0x0800.
- i_phase_ofs=0x4000 with FCW=0x2000 → o_phase = 0x6000, 0x0000, 0x2000, … (offset wraps modulo 2^15). o_wrap follows acc, not the offset sum.
- In PEND, assert i_sync → acc=0, the pending FCW is applied immediately, and o_fcw_ready goes high on the next cycle. Then assert i_rst in RUN → all outputs 0 on the following cycle; after reset the accumulator restarts from 0 with FCW 0 until a new word is loaded.
- Drop i_en for 3 cycles mid-run → o_valid low for exactly 3 cycles, delayed 2 cycles from i_en. When i_en returns, the phase resumes from the held value with no skipped steps.
